// File: rtl/tt_input_debounce.sv
// Purpose : 2-flop sync + per-bit debounce of ui_in into stable levels, rise/fall pulses and optional auto-repeat.
// Latency : an input held steady is accepted DEBOUNCE_CYCLES+1 edges after it first reaches the input.
// Backpr. : none; free-running, pulses are single-cycle. Optional auto-repeat via TT_DEBOUNCE_AUTOREPEAT_EN.
module tt_input_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any,
  output logic [WIDTH-1:0] sw_repeat
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("tt_input_debounce: parameter out of legal range");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Two-flop synchronizer; runs regardless of ena so it is settled when ena rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ui_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit run counter: any agreeing cycle (or ena low) clears it, a full run flips the level.
  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (ena && (sync2_q[i] != state_q[i])) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = ~state_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Debounce state, counters and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_state = state_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign sw_any   = any_q;

`ifdef TT_DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RW-1:0]    rcnt_q [WIDTH];
  logic [RW-1:0]    rcnt_d [WIDTH];
  logic [RW-1:0]    rnxt;
  logic [WIDTH-1:0] rep_q, rep_d;

  // Cycles-held counter: first pulse at REPEAT_DELAY, then wraps back to fire every REPEAT_PERIOD.
  always_comb begin
    rep_d = '0;
    rnxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rcnt_d[i] = '0;
      if (ena && state_q[i] && !fall_d[i]) begin
        rnxt      = rcnt_q[i] + RW'(1);
        rcnt_d[i] = rnxt;
        if (rnxt == R_FIRST) begin
          rep_d[i] = 1'b1;
        end else if (rnxt == R_WRAP) begin
          rep_d[i]  = 1'b1;
          rcnt_d[i] = R_FIRST;
        end
      end
    end
  end

  // Repeat counters and registered repeat pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
      for (int i = 0; i < WIDTH; i++) rcnt_q[i] <= '0;
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < WIDTH; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  assign sw_repeat = rep_q;
`else
  assign sw_repeat = '0;
`endif

endmodule

// File: tb/tb_tt_input_debounce.sv
// Purpose : checks tt_input_debounce (DEBOUNCE_CYCLES=4 and =1) against a run-length reference model.
// Latency : model predicts every output every cycle; directed phases count pulses per scenario.
// Backpr. : n/a; stimulus is fixed-length, random phase uses $urandom.
module tb_tt_input_debounce;

  localparam int W  = 8;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] ui_in;

  logic [W-1:0] d_state [2];
  logic [W-1:0] d_rise  [2];
  logic [W-1:0] d_fall  [2];
  logic [W-1:0] d_rep   [2];
  logic         d_any   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tt_input_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .sw_state(d_state[0]), .sw_rise(d_rise[0]), .sw_fall(d_fall[0]),
    .sw_any(d_any[0]), .sw_repeat(d_rep[0])
  );

  tt_input_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .sw_state(d_state[1]), .sw_rise(d_rise[1]), .sw_fall(d_fall[1]),
    .sw_any(d_any[1]), .sw_repeat(d_rep[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: inputs reach the debouncer through a two-sample delay line;
  // a level is accepted after DC consecutive disagreeing samples while enabled.
  logic [W-1:0] ui_q [$];
  logic [W-1:0] m_state [2];
  logic [W-1:0] m_rise  [2];
  logic [W-1:0] m_fall  [2];
  logic [W-1:0] m_rep   [2];
  logic         m_any   [2];
  int           run [2][W];
  int           age [2][W];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_q = '{8'h00, 8'h00};
      for (int n = 0; n < 2; n++) begin
        m_state[n] = '0; m_rise[n] = '0; m_fall[n] = '0; m_rep[n] = '0; m_any[n] = 1'b0;
        for (int i = 0; i < W; i++) begin run[n][i] = 0; age[n][i] = 0; end
      end
    end else begin
      logic [W-1:0] s;
      s = ui_q.pop_front();
      ui_q.push_back(ui_in);
      for (int n = 0; n < 2; n++) begin
        int dc;
        dc = (n == 0) ? 4 : 1;
        m_rise[n] = '0; m_fall[n] = '0; m_rep[n] = '0;
        for (int i = 0; i < W; i++) begin
          bit accept;
          accept = 1'b0;
          if (!ena) begin
            run[n][i] = 0;
            age[n][i] = 0;
          end else begin
            if (s[i] != m_state[n][i]) run[n][i]++;
            else run[n][i] = 0;
            if (run[n][i] == dc) begin accept = 1'b1; run[n][i] = 0; end
            if (m_state[n][i] && !accept) begin
              age[n][i]++;
`ifdef TT_DEBOUNCE_AUTOREPEAT_EN
              if (age[n][i] >= RD && ((age[n][i] - RD) % RP) == 0) m_rep[n][i] = 1'b1;
`endif
            end else begin
              age[n][i] = 0;
            end
            if (accept) begin
              m_state[n][i] = ~m_state[n][i];
              m_rise[n][i]  = m_state[n][i];
              m_fall[n][i]  = ~m_state[n][i];
            end
          end
        end
        m_any[n] = |(m_rise[n] | m_fall[n]);
      end
    end
  end

  // Scenario counters on the DEBOUNCE_CYCLES=4 instance.
  int c_riseff = 0, c_rise0 = 0, c_fall0 = 0, c_rise3 = 0;
  int c_simul = 0, c_any = 0, c_rise1 = 0, c_rep2 = 0;
  bit chk_en = 1'b1;

  // Compare every output of both instances with the model, 2 time units after each edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        check_val($sformatf("state%0d", n), 32'(d_state[n]), 32'(m_state[n]));
        check_val($sformatf("rise%0d", n),  32'(d_rise[n]),  32'(m_rise[n]));
        check_val($sformatf("fall%0d", n),  32'(d_fall[n]),  32'(m_fall[n]));
        check_val($sformatf("any%0d", n),   32'(d_any[n]),   32'(m_any[n]));
        check_val($sformatf("repeat%0d", n), 32'(d_rep[n]),  32'(m_rep[n]));
      end
      if (d_rise[0] == 8'hFF) c_riseff++;
      if (d_rise[0][0]) c_rise0++;
      if (d_fall[0][0]) c_fall0++;
      if (d_rise[0][3]) c_rise3++;
      if (d_rise[0] == 8'hF0 && d_fall[0] == 8'h0F) c_simul++;
      if (d_any[0]) c_any++;
      if (d_rise[0][1]) c_rise1++;
      if (d_rep[0][2]) c_rep2++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b0, b1, b2;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'hFF;
    cycles(5);
    rst_n = 1'b1;
    cycles(10);
    check_val("reset_rise_ff_once", 32'(c_riseff), 32'd1);

    // Clean edge on bit 0 after all bits settle low.
    ui_in = 8'h00;
    cycles(10);
    b0 = c_rise0; b1 = c_fall0;
    ui_in = 8'h01;
    cycles(10);
    check_val("clean_rise0", 32'(c_rise0 - b0), 32'd1);
    check_val("clean_no_fall0", 32'(c_fall0 - b1), 32'd0);

    // Bounce on bit 3: runs of 3 never reach 4.
    b0 = c_rise3;
    ui_in = 8'h09; cycles(3);
    ui_in = 8'h01; cycles(1);
    ui_in = 8'h09; cycles(3);
    ui_in = 8'h01; cycles(5);
    check_val("bounce_no_rise3", 32'(c_rise3 - b0), 32'd0);
    ui_in = 8'h09; cycles(10);
    check_val("bounce_then_rise3", 32'(c_rise3 - b0), 32'd1);

    // Simultaneous rise and fall across the nibbles.
    ui_in = 8'h0F; cycles(10);
    b0 = c_simul;
    ui_in = 8'hF0; cycles(10);
    check_val("simul_pulses", 32'(c_simul - b0), 32'd1);

    // Enable gating while bit 1 toggles and then holds.
    b0 = c_any;
    ena = 1'b0;
    ui_in = 8'hF2; cycles(1);
    ui_in = 8'hF0; cycles(1);
    ui_in = 8'hF2; cycles(1);
    ui_in = 8'hF0; cycles(1);
    ui_in = 8'hF2; cycles(20);
    check_val("ena_low_no_pulse", 32'(c_any - b0), 32'd0);
    b1 = c_rise1;
    ena = 1'b1;
    cycles(10);
    check_val("ena_restart_rise1", 32'(c_rise1 - b1), 32'd1);

    // Hold bit 2 for 30 cycles, then release.
    b2 = c_rep2;
    ui_in = 8'hF6; cycles(30);
    ui_in = 8'hF2; cycles(15);
`ifdef TT_DEBOUNCE_AUTOREPEAT_EN
    check_val("repeat2_count", 32'(c_rep2 - b2), 32'd7);
`else
    check_val("repeat2_count", 32'(c_rep2 - b2), 32'd0);
`endif

    // Random phase with enable drops and one mid-activity reset.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) rst_n = 1'b0;
      if (k == 1503) rst_n = 1'b1;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) ui_in[b] = ~ui_in[b];
      if (ena) begin
        if ($urandom_range(0, 79) == 0) ena = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        ena = 1'b1;
      end
      cycles(1);
    end

    chk_en = 1'b0;
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_input_debounce.md
Name: tt_input_debounce

Overview:
- Input-side conditioning block for the Tiny Tapeout user inputs. Takes the raw switch/button bus `ui_in` and produces clean signals for the design logic: synchronized, debounced levels plus one-cycle rise/fall pulses.
- It is the counterpart of the display output path (`uo_out`).
- Instantiated inside `tt_um_*` between `ui_in` and the design logic.

Parameters:
- WIDTH, 8, number of input bits conditioned.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from the stable level before it is accepted; legal range 1..65535.
- REPEAT_DELAY, 1000, cycles a bit must be held high before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 200, cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; high = conditioning active
- ui_in  in  WIDTH  raw, asynchronous switch/button inputs
- sw_state  out  WIDTH  debounced stable level per bit
- sw_rise  out  WIDTH  one-cycle pulse when a bit's stable level goes 0->1
- sw_fall  out  WIDTH  one-cycle pulse when a bit's stable level goes 1->0
- sw_any  out  1  OR of all sw_rise and sw_fall bits, registered in the same cycle
- sw_repeat  out  WIDTH  auto-repeat pulses (0 unless the optional feature is compiled in)

Behaviour:
- One clock domain. Reset is asynchronous and active-low: `rst_n` low immediately clears all state. Ports are named `clk` and `rst_n`.
- Reset values: sync flops, sw_state, counters, sw_rise, sw_fall, sw_any and sw_repeat are all 0.
- Synchronizer: a 2-flop synchronizer per bit runs continuously, regardless of `ena`. Its output is `s[i]`.
- Per-bit debounce uses a counter `cnt[i]`, $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - If `s[i]` equals `sw_state[i]`: `cnt[i]` <= 0.
  - If `s[i]` differs and `cnt[i]` == DEBOUNCE_CYCLES-1: `sw_state[i]` toggles, `cnt[i]` <= 0, and the matching sw_rise/sw_fall bit is high for that cycle only.
  - Otherwise: `cnt[i]` increments.
- Latency: if `ui_in[i]` changes before edge 0 and stays there, `sw_state[i]` and the pulse are visible after edge DEBOUNCE_CYCLES+1.
- Bounce: any cycle with `s[i]` equal to `sw_state[i]` clears `cnt[i]`; partial counts never carry over.
- Bits are fully independent. Simultaneous acceptances on several bits raise several pulse bits in the same cycle.
- sw_rise and sw_fall for the same bit are never high together. All pulse outputs are registered.
- `ena` low:
  - All counters are held at 0 and sw_state is frozen.
  - sw_rise, sw_fall, sw_any and sw_repeat are 0.
  - When `ena` returns high, debouncing restarts from count 0 against the frozen sw_state.
- Reset mid-count discards the count. After release the block needs DEBOUNCE_CYCLES+1 cycles to accept an input held high.
- DEBOUNCE_CYCLES = 1 is legal: acceptance after 2 edges, i.e. synchronizer latency only.

Optional Feature:
- Macro: TT_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Each bit gets a repeat counter, cleared whenever `sw_state[i]` is 0, `ena` is 0, or on reset.
  - While `sw_state[i]` is 1, `sw_repeat[i]` pulses for one cycle REPEAT_DELAY cycles after the sw_rise pulse.
  - Further pulses follow every REPEAT_PERIOD cycles until the bit is released.
  - The sw_rise cycle itself never produces a repeat pulse.
  - Release (sw_fall) stops repeats in the same cycle.
- Not defined: `sw_repeat` is tied to 0 and no repeat counters are synthesized. The port list is unchanged.

Test Plan:
- Reset: rst_n=0 with ui_in=8'hFF, released at cycle 5; DEBOUNCE_CYCLES=4 -> all outputs 0 during reset; sw_state=8'hFF and sw_rise=8'hFF for exactly one cycle, 5 edges after release; sw_any=1 in that cycle.
- Clean edge: DEBOUNCE_CYCLES=4, ui_in[0] 0->1 before edge 0 -> sw_state[0]=1 and sw_rise[0]=1 after edge 5; sw_rise[0]=0 after edge 6; no sw_fall.
- Bounce: ui_in[3] high 3 cycles, low 1, high 3, low (DEBOUNCE_CYCLES=4) -> sw_state[3] stays 0 and no pulses; then held high 10 cycles -> exactly one sw_rise[3].
- Simultaneous: ui_in 8'h0F->8'hF0 in one cycle after settling -> sw_rise=8'hF0 and sw_fall=8'h0F in the same cycle; sw_state=8'hF0.
- Enable gating: ena=0 while ui_in[1] toggles and is held 20 cycles -> sw_state unchanged, no pulses; ena=1 -> sw_rise[1] 4 cycles later (counter restarts; synchronizer already settled).
- Auto-repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=3): hold ui_in[2] -> sw_repeat[2] pulses 10 cycles after sw_rise, then every 3 cycles; release -> no further pulses. Same stimulus without the macro -> sw_repeat always 0.
